prog_updown_counter: RTL and testbench

- Parameterised successor to the 3-bit load/enable counter.
- Adds generic width, up/down direction, a programmable terminal value (limit), and three end-of-range modes: wrap, saturate and one-shot.
- Adds a sticky overflow flag and registered event pulses.
- Sits beside datapath timers and sequencers as a general-purpose event/interval counter. Its SVA property module is bound in from the testbench.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_step.sv | 53 +++++
 rtl/counter_step_props.sv | 25 ++
 rtl/prog_updown_counter.sv | 84 ++++++++
 tb/tb_prog_updown_counter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the programmable up/down counter.
// The mode and FSM encodings are used by both the step logic and the top.
package counter_pkg;

   typedef enum logic [1:0] {
      WRAP    = 2'd0,
      SAT     = 2'd1,
      ONESHOT = 2'd2,
      RSVD    = 2'd3
   } mode_e;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_e;

   localparam int unsigned WIDTH_DEF   = 8;
   localparam int unsigned RST_VAL_DEF = 0;

endpackage

// File: rtl/counter_step.sv
// Combinational single-step logic: next count plus wrap / overflow / one-shot events.
// Load is not handled here; the top gives a load priority over any step.
module counter_step
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] limit,
   input  logic             up_dn,
   input  mode_e            mode,
   input  logic             count_enb,
   output logic [WIDTH-1:0] next_count,
   output logic             wrap,
   output logic             ovf_set,
   output logic             done_set
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic at_term;

   // A count left above a lowered limit is terminal going up, plain decrement going down.
   assign at_term = up_dn ? (count >= limit) : (count == '0);

   always_comb begin
      next_count = count;
      wrap       = 1'b0;
      ovf_set    = 1'b0;
      done_set   = 1'b0;
      if (count_enb) begin
         if (!at_term) begin
            next_count = up_dn ? (count + ONE) : (count - ONE);
         end else begin
            case (mode)
               SAT: begin
                  next_count = up_dn ? limit : count;
                  ovf_set    = 1'b1;
               end
               ONESHOT: begin
                  next_count = up_dn ? limit : count;
                  done_set   = 1'b1;
               end
               default: begin
                  next_count = up_dn ? '0 : limit;
                  wrap       = 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/counter_step_props.sv
// Assertion checker for prog_updown_counter; attached with a bind statement.
// Covers terminal-count decode, post-load range and count stability while done.
module counter_step_props #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   input logic             ld_enb,
   input logic [WIDTH-1:0] limit,
   input logic             up_dn,
   input logic [WIDTH-1:0] count,
   input logic             tc,
   input logic             done
);

   tc_decode: assert property (@(posedge clk)
      tc == (up_dn ? (count == limit) : (count == '0)));

   load_in_range: assert property (@(posedge clk) disable iff (rst)
      ld_enb |=> (count <= $past(limit)));

   done_holds: assert property (@(posedge clk) disable iff (rst)
      (done && !ld_enb) |=> (count == $past(count)));

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with wrap / saturate / one-shot end-of-range modes,
// sticky overflow flag and registered wrap pulse.
module prog_updown_counter
   import counter_pkg::*;
#(
   parameter int          WIDTH   = WIDTH_DEF,
   parameter int unsigned RST_VAL = RST_VAL_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_enb,
   input  logic [WIDTH-1:0] data_in,
   input  logic             count_enb,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count_out,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             ovf,
   output logic             done
);

   localparam logic [WIDTH-1:0] RST_CNT = RST_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] count_p0, count_nxt, step_count;
   logic             wrap_p0, wrap_nxt, step_wrap;
   logic             ovf_p0, ovf_nxt, step_ovf;
   logic             step_done;
   state_e           state_p0, state_nxt;

   counter_step #(.WIDTH(WIDTH)) u_step (
      .count      (count_p0),
      .limit      (limit),
      .up_dn      (up_dn),
      .mode       (mode_e'(mode)),
      .count_enb  (count_enb && (state_p0 == RUN)),
      .next_count (step_count),
      .wrap       (step_wrap),
      .ovf_set    (step_ovf),
      .done_set   (step_done)
   );

   // Next-state: load beats step; a set of ovf beats a same-edge clear.
   always_comb begin
      count_nxt = count_p0;
      wrap_nxt  = 1'b0;
      ovf_nxt   = ovf_p0 && !clr_ovf;
      state_nxt = state_p0;
      if (ld_enb) begin
         count_nxt = (data_in > limit) ? limit : data_in;
         if (data_in > limit) ovf_nxt = 1'b1;
         state_nxt = RUN;
      end else begin
         count_nxt = step_count;
         wrap_nxt  = step_wrap;
         if (step_ovf)  ovf_nxt   = 1'b1;
         if (step_done) state_nxt = DONE;
      end
   end

   // Stage p0: architectural state
   always_ff @(posedge clk) begin
      if (rst) begin
         count_p0 <= RST_CNT;
         wrap_p0  <= 1'b0;
         ovf_p0   <= 1'b0;
         state_p0 <= RUN;
      end else begin
         count_p0 <= count_nxt;
         wrap_p0  <= wrap_nxt;
         ovf_p0   <= ovf_nxt;
         state_p0 <= state_nxt;
      end
   end

   assign count_out  = count_p0;
   assign wrap_pulse = wrap_p0;
   assign ovf        = ovf_p0;
   assign done       = (state_p0 == DONE);
   assign tc         = up_dn ? (count_p0 == limit) : (count_p0 == '0);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Vector-table bench for prog_updown_counter (WIDTH=3) with an expected-result queue.
module tb_prog_updown_counter;

   localparam int WIDTH = 3;

   logic             clk = 1'b0;
   logic             rst, ld_enb, count_enb, up_dn, clr_ovf;
   logic [WIDTH-1:0] data_in, limit, count_out;
   logic [1:0]       mode;
   logic             tc, wrap_pulse, ovf, done;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string nm;
      bit    r, ld;
      int    din;
      bit    en, up;
      int    md, lim;
      bit    clr;
      int    cnt;
      bit    wp, ov, dn, t;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   prog_updown_counter #(.WIDTH(WIDTH), .RST_VAL(0)) dut (
      .clk(clk), .rst(rst), .ld_enb(ld_enb), .data_in(data_in),
      .count_enb(count_enb), .up_dn(up_dn), .mode(mode), .limit(limit),
      .clr_ovf(clr_ovf), .count_out(count_out), .tc(tc),
      .wrap_pulse(wrap_pulse), .ovf(ovf), .done(done)
   );

   bind prog_updown_counter counter_step_props #(.WIDTH(WIDTH)) u_props (
      .clk(clk), .rst(rst), .ld_enb(ld_enb), .limit(limit), .up_dn(up_dn),
      .count(count_out), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(string nm, bit r, bit ld, int din, bit en, bit up,
                               int md, int lim, bit clr,
                               int cnt, bit wp, bit ov, bit dn, bit t);
      vec_t v;
      v.nm = nm; v.r = r; v.ld = ld; v.din = din; v.en = en; v.up = up;
      v.md = md; v.lim = lim; v.clr = clr;
      v.cnt = cnt; v.wp = wp; v.ov = ov; v.dn = dn; v.t = t;
      return v;
   endfunction

   task automatic chk(string nm, int got, int expv);
      n_total++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
   endtask

   task automatic apply(vec_t v);
      vec_t e;
      rst       = v.r;
      ld_enb    = v.ld;
      data_in   = WIDTH'(v.din);
      count_enb = v.en;
      up_dn     = v.up;
      mode      = 2'(v.md);
      limit     = WIDTH'(v.lim);
      clr_ovf   = v.clr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({e.nm, ".count"}, int'(count_out), e.cnt);
      chk({e.nm, ".wrap"},  int'(wrap_pulse), int'(e.wp));
      chk({e.nm, ".ovf"},   int'(ovf), int'(e.ov));
      chk({e.nm, ".done"},  int'(done), int'(e.dn));
      chk({e.nm, ".tc"},    int'(tc), int'(e.t));
   endtask

   initial begin
      //                nm            r  ld din en up md lim clr  cnt wp ov dn tc
      vecs.push_back(mk("reset",      1, 0, 0, 0, 1, 0, 5, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("wrap_up1",   0, 0, 0, 1, 1, 0, 5, 0,   1, 0, 0, 0, 0));
      vecs.push_back(mk("wrap_up2",   0, 0, 0, 1, 1, 0, 5, 0,   2, 0, 0, 0, 0));
      vecs.push_back(mk("wrap_up3",   0, 0, 0, 1, 1, 0, 5, 0,   3, 0, 0, 0, 0));
      vecs.push_back(mk("wrap_up4",   0, 0, 0, 1, 1, 0, 5, 0,   4, 0, 0, 0, 0));
      vecs.push_back(mk("wrap_up5",   0, 0, 0, 1, 1, 0, 5, 0,   5, 0, 0, 0, 1));
      vecs.push_back(mk("wrap_up6",   0, 0, 0, 1, 1, 0, 5, 0,   0, 1, 0, 0, 0));
      vecs.push_back(mk("wrap_up7",   0, 0, 0, 1, 1, 0, 5, 0,   1, 0, 0, 0, 0));
      vecs.push_back(mk("sat_ld",     0, 1, 2, 0, 0, 1, 5, 0,   2, 0, 0, 0, 0));
      vecs.push_back(mk("sat_dn1",    0, 0, 0, 1, 0, 1, 5, 0,   1, 0, 0, 0, 0));
      vecs.push_back(mk("sat_dn2",    0, 0, 0, 1, 0, 1, 5, 0,   0, 0, 0, 0, 1));
      vecs.push_back(mk("sat_dn3",    0, 0, 0, 1, 0, 1, 5, 0,   0, 0, 1, 0, 1));
      vecs.push_back(mk("sat_dn4",    0, 0, 0, 1, 0, 1, 5, 0,   0, 0, 1, 0, 1));
      vecs.push_back(mk("sat_hold",   0, 0, 0, 0, 0, 1, 5, 0,   0, 0, 1, 0, 1));
      vecs.push_back(mk("sat_clrset", 0, 0, 0, 1, 0, 1, 5, 1,   0, 0, 1, 0, 1));
      vecs.push_back(mk("sat_clr",    0, 0, 0, 0, 0, 1, 5, 1,   0, 0, 0, 0, 1));
      vecs.push_back(mk("os_ld",      0, 1, 1, 0, 1, 2, 3, 0,   1, 0, 0, 0, 0));
      vecs.push_back(mk("os_step1",   0, 0, 0, 1, 1, 2, 3, 0,   2, 0, 0, 0, 0));
      vecs.push_back(mk("os_step2",   0, 0, 0, 1, 1, 2, 3, 0,   3, 0, 0, 0, 1));
      vecs.push_back(mk("os_term",    0, 0, 0, 1, 1, 2, 3, 0,   3, 0, 0, 1, 1));
      vecs.push_back(mk("os_ignore",  0, 0, 0, 1, 1, 2, 3, 0,   3, 0, 0, 1, 1));
      vecs.push_back(mk("os_reload",  0, 1, 0, 1, 1, 2, 3, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("clamp",      0, 1, 7, 0, 1, 0, 4, 0,   4, 0, 1, 0, 1));
      vecs.push_back(mk("prio",       0, 1, 2, 1, 1, 0, 6, 1,   2, 0, 0, 0, 0));
      vecs.push_back(mk("prio_step",  0, 0, 0, 1, 1, 0, 6, 0,   3, 0, 0, 0, 0));
      vecs.push_back(mk("ld_clamp6",  0, 1, 7, 0, 1, 0, 6, 0,   6, 0, 1, 0, 1));
      vecs.push_back(mk("ld5",        0, 1, 5, 0, 1, 0, 6, 0,   5, 0, 1, 0, 0));
      vecs.push_back(mk("rst_mid",    1, 0, 0, 1, 1, 0, 6, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("lim_ld6",    0, 1, 6, 0, 1, 0, 7, 0,   6, 0, 0, 0, 0));
      vecs.push_back(mk("lim_low",    0, 0, 0, 1, 1, 0, 3, 0,   0, 1, 0, 0, 0));
      vecs.push_back(mk("lim_low2",   0, 0, 0, 1, 1, 0, 3, 0,   1, 0, 0, 0, 0));
      vecs.push_back(mk("sat_oor_ld", 0, 1, 6, 0, 1, 1, 7, 0,   6, 0, 0, 0, 0));
      vecs.push_back(mk("sat_oor",    0, 0, 0, 1, 1, 1, 3, 0,   3, 0, 1, 0, 1));
      vecs.push_back(mk("os_oor_ld",  0, 1, 6, 0, 1, 2, 7, 1,   6, 0, 0, 0, 0));
      vecs.push_back(mk("os_oor",     0, 0, 0, 1, 1, 2, 3, 0,   3, 0, 0, 1, 1));
      vecs.push_back(mk("os_modechg", 0, 0, 0, 1, 1, 0, 3, 0,   3, 0, 0, 1, 1));
      vecs.push_back(mk("os_rst",     1, 0, 0, 1, 1, 0, 3, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("lim0_a",     0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 0, 1));
      vecs.push_back(mk("lim0_b2b",   0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 0, 1));
      vecs.push_back(mk("lim0_idle",  0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1));
      vecs.push_back(mk("lim0_dn",    0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1));
      vecs.push_back(mk("rsvd_ld",    0, 1, 2, 0, 1, 3, 2, 0,   2, 0, 0, 0, 1));
      vecs.push_back(mk("rsvd_wrap",  0, 0, 0, 1, 1, 3, 2, 0,   0, 1, 0, 0, 0));

      rst = 1'b1; ld_enb = 1'b0; data_in = '0; count_enb = 1'b0;
      up_dn = 1'b1; mode = 2'd0; limit = 3'd5; clr_ovf = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) apply(vecs[i]);

      // tc must follow up_dn without waiting for a clock edge
      apply(mk("rst_again", 1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      up_dn = 1'b0;
      #1;
      chk("tc_comb_down", int'(tc), 1);
      up_dn = 1'b1;
      #1;
      chk("tc_comb_up", int'(tc), 0);

      // Done, then clear-only cycle must neither leave DONE nor move count
      apply(mk("hs_os_ld",   0, 1, 2, 0, 1, 2, 2, 0, 2, 0, 0, 0, 1));
      apply(mk("hs_os_term", 0, 0, 0, 1, 1, 2, 2, 0, 2, 0, 0, 1, 1));
      apply(mk("hs_os_clr",  0, 0, 0, 1, 0, 2, 2, 1, 2, 0, 0, 1, 0));
      apply(mk("hs_os_exit", 0, 1, 1, 0, 1, 2, 2, 0, 1, 0, 0, 0, 0));

      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
